mux_4_rr_arbiter: RTL and testbench
===================================

// Module: mux_4_rr_arbiter
// PURPOSE
//  Shares one 4:1 datapath mux between four valid/ready requesters (ports a..d = 0..3).
//  Picks a winner by round-robin, holds sel for a burst of up to BURST_LEN beats, then
//  rotates priority. Sits between the four producers and a single downstream consumer.
// PARAMETERS
//  WIDTH      8   data width of each requester and of out_data
//  BURST_LEN  4   max beats accepted per grant before forced release; legal 1..256
// PORTS
//  clk        in   1        single clock; all state on rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  in_valid   in   4        request/valid per requester; bit i = requester i
//  in_data    in   4*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  in_ready   out  4        accept strobe per requester
//  out_valid  out  1        beat presented to consumer
//  out_data   out  WIDTH    muxed data of granted requester
//  out_ready  in   1        consumer accepts the beat when out_valid && out_ready
//  sel        out  2        registered mux select: 00=a, 01=b, 10=c, 11=d
//  grant      out  4        one-hot grant, 0 when idle
//  busy       out  1        1 while in GRANT
// BEHAVIOUR
//  Reset (async on rst_n=0): state=IDLE, ptr=0, sel=00, beat_cnt=0; hence grant=0,
//   busy=0, out_valid=0, in_ready=0 immediately, mid-burst included. Beat in flight is dropped.
//  State IDLE: out_valid=0, in_ready=0. If any in_valid at edge: winner = first i with
//   in_valid[i], searching ptr, ptr+1, ... mod 4; sel<=winner, beat_cnt<=0, -> GRANT.
//   No valid: stay IDLE. Latency: request at edge N -> grant/out_valid after edge N+1.
//  State GRANT: grant=onehot(sel); out_valid=in_valid[sel]; out_data=in_data[sel];
//   in_ready[sel]=out_ready, other in_ready bits 0 (combinational, no added latency).
//  Accept = out_valid && out_ready; each accept increments beat_cnt.
//  Release, at the edge where either holds: (accept && beat_cnt==BURST_LEN-1) or
//   in_valid[sel]==0. On release: ptr<=sel+1 (mod 4), -> IDLE.
//  No release while in_valid[sel]=1 and burst not exhausted, even if out_ready=0 for
//   many cycles (no timeout).
//  Requesters hold valid and data stable until accepted; dropping valid is treated as
//   end of burst, not an error.
//  Gap: one IDLE cycle between grants (max throughput BURST_LEN beats per BURST_LEN+1 cycles).
//  BURST_LEN=1: release after every accept, so strict per-beat round-robin.
//  beat_cnt width = max(1,$clog2(BURST_LEN)); never exceeds BURST_LEN-1, no wrap.
//  ptr wraps 3->0. sel changes only on IDLE->GRANT, so the mux select is glitch-free.
//  Non-granted in_valid are ignored; no request is lost, it waits for its turn.
//  Starvation bound: a held request is granted within 3 other grants.
// TESTING
//  1 All four valid from reset, out_ready=1, BURST_LEN=4, each sending 8 beats ->
//    grant order a,b,c,d,a,b,c,d with 4 beats each and 1 idle cycle between grants.
//  2 Only c valid, 10 beats, out_ready=1 -> sel=10; bursts of 4,4,2 and re-grant to c
//    after each release; in_ready[a,b,d] stay 0 throughout.
//  3 b granted, out_ready=0 for 20 cycles -> out_valid=1, sel=01 held, beat_cnt=0;
//    out_ready=1 -> beats resume with no data lost or duplicated.
//  4 a drops valid after 2 of 4 beats while d is valid -> release, ptr=1, next grant d;
//    a re-requesting is granted after d.
//  5 rst_n=0 mid-burst on c (beat_cnt=2) -> same cycle grant=0, out_valid=0, busy=0;
//    after release first grant follows ptr=0 (a if valid).
//  6 BURST_LEN=1, a and c valid -> alternating a,c,a,c single beats with 1-cycle gaps.

Source files
------------

// File: rtl/mux_4_rr_arbiter.sv
// Four-way round-robin arbiter that owns a shared 4:1 data mux.
// A winner keeps the mux for up to BURST_LEN accepted beats, or until it drops
// valid, after which priority rotates to the requester after the winner.
module mux_4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         i_in_valid,
  input  logic [4*WIDTH-1:0] i_in_data,
  output logic [3:0]         o_in_ready,
  output logic               o_out_valid,
  output logic [WIDTH-1:0]   o_out_data,
  input  logic               i_out_ready,
  output logic [1:0]         o_sel,
  output logic [3:0]         o_grant,
  output logic               o_busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptrNext;
  logic [1:0]       r_sel;
  logic [1:0]       w_selNext;
  logic [CNT_W-1:0] r_beatCnt;
  logic [CNT_W-1:0] w_beatCntNext;

  logic [7:0]       w_validDbl;
  logic [3:0]       w_validRot;
  logic [1:0]       w_offset;
  logic [1:0]       w_winner;
  logic             w_selValid;
  logic             w_accept;
  logic             w_lastBeat;

  assign o_sel = r_sel;

  // Rotate the requests so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    w_validDbl = {i_in_valid, i_in_valid} >> r_ptr;
    w_validRot = w_validDbl[3:0];
    w_offset   = 2'd3;
    if (w_validRot[2]) w_offset = 2'd2;
    if (w_validRot[1]) w_offset = 2'd1;
    if (w_validRot[0]) w_offset = 2'd0;
    w_winner   = r_ptr + w_offset;
  end

  // Datapath and handshake steering: only the granted requester sees out_ready.
  always_comb begin
    w_selValid  = i_in_valid[r_sel];
    o_busy      = (r_state == ST_GRANT);
    o_out_data  = i_in_data[r_sel*WIDTH +: WIDTH];
    o_grant     = 4'b0000;
    o_in_ready  = 4'b0000;
    o_out_valid = 1'b0;
    if (r_state == ST_GRANT) begin
      o_grant[r_sel]    = 1'b1;
      o_out_valid       = w_selValid;
      o_in_ready[r_sel] = i_out_ready;
    end
    w_accept   = o_out_valid && i_out_ready;
    w_lastBeat = (r_beatCnt == LAST_BEAT);
  end

  // Next-state logic: grant on any request, release on exhausted burst or dropped valid.
  always_comb begin
    w_stateNext   = r_state;
    w_ptrNext     = r_ptr;
    w_selNext     = r_sel;
    w_beatCntNext = r_beatCnt;
    case (r_state)
      ST_IDLE: begin
        if (|i_in_valid) begin
          w_selNext     = w_winner;
          w_beatCntNext = '0;
          w_stateNext   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_selValid || (w_accept && w_lastBeat)) begin
          w_ptrNext   = r_sel + 2'd1;
          w_stateNext = ST_IDLE;
        end else if (w_accept) begin
          w_beatCntNext = r_beatCnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any beat in flight and restarts priority at requester a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_sel     <= 2'd0;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_ptr     <= w_ptrNext;
      r_sel     <= w_selNext;
      r_beatCnt <= w_beatCntNext;
    end
  end

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// Directed bench for mux_4_rr_arbiter: a BURST_LEN=4 instance checked against a
// vector table plus hand sequences, and a BURST_LEN=1 instance sharing the same inputs.
module tb_mux_4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] data;
  logic        ordy;

  logic [3:0]  o4InReady;
  logic        o4OutValid;
  logic [7:0]  o4OutData;
  logic [1:0]  o4Sel;
  logic [3:0]  o4Grant;
  logic        o4Busy;

  logic [3:0]  o1InReady;
  logic        o1OutValid;
  logic [7:0]  o1OutData;
  logic [1:0]  o1Sel;
  logic [3:0]  o1Grant;
  logic        o1Busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic        busy;
    logic [1:0]  sel;
    logic [3:0]  grant;
    logic        ov;
    logic [3:0]  ir;
    logic [7:0]  odata;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D1 = 32'h44332211;

  mux_4_rr_arbiter #(.WIDTH(8), .BURST_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(valid), .i_in_data(data), .o_in_ready(o4InReady),
    .o_out_valid(o4OutValid), .o_out_data(o4OutData), .i_out_ready(ordy),
    .o_sel(o4Sel), .o_grant(o4Grant), .o_busy(o4Busy)
  );

  mux_4_rr_arbiter #(.WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(valid), .i_in_data(data), .o_in_ready(o1InReady),
    .o_out_valid(o1OutValid), .o_out_data(o1OutData), .i_out_ready(ordy),
    .o_sel(o1Sel), .o_grant(o1Grant), .o_busy(o1Busy)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic r,
                              input logic b, input logic [1:0] s, input logic [3:0] g,
                              input logic ov, input logic [3:0] ir, input logic [7:0] od);
    vec_t t;
    t.valid = v; t.data = d; t.ordy = r;
    t.busy = b; t.sel = s; t.grant = g; t.ov = ov; t.ir = ir; t.odata = od;
    return t;
  endfunction

  function automatic vec_t idleRow(input logic [3:0] v, input logic [31:0] d, input logic [1:0] s);
    return mk(v, d, 1'b1, 1'b0, s, 4'b0000, 1'b0, 4'b0000, 8'h00);
  endfunction

  function automatic vec_t grantRow(input logic [3:0] v, input logic [31:0] d, input logic r,
                                    input logic [1:0] s, input logic ov, input logic [7:0] od);
    return mk(v, d, r, 1'b1, s, 4'b0001 << s, ov, r ? (4'b0001 << s) : 4'b0000, od);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    valid = v.valid;
    data  = v.data;
    ordy  = v.ordy;
  endtask

  task automatic checkOutput(input string tag, input int dutSel, input vec_t e);
    logic       aBusy;
    logic [1:0] aSel;
    logic [3:0] aGrant;
    logic       aOv;
    logic [3:0] aIr;
    logic [7:0] aData;
    if (dutSel == 0) begin
      aBusy = o4Busy; aSel = o4Sel; aGrant = o4Grant; aOv = o4OutValid; aIr = o4InReady; aData = o4OutData;
    end else begin
      aBusy = o1Busy; aSel = o1Sel; aGrant = o1Grant; aOv = o1OutValid; aIr = o1InReady; aData = o1OutData;
    end
    cmp($sformatf("%s.busy", tag),      32'(aBusy),  32'(e.busy));
    cmp($sformatf("%s.sel", tag),       32'(aSel),   32'(e.sel));
    cmp($sformatf("%s.grant", tag),     32'(aGrant), 32'(e.grant));
    cmp($sformatf("%s.out_valid", tag), 32'(aOv),    32'(e.ov));
    cmp($sformatf("%s.in_ready", tag),  32'(aIr),    32'(e.ir));
    if (e.ov) cmp($sformatf("%s.out_data", tag), 32'(aData), 32'(e.odata));
  endtask

  task automatic runVec(input string tag, input int dutSel, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(tag, dutSel, v);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 4'b0000;
    data  = 32'h0;
    ordy  = 1'b0;
    #1;
    checkOutput("reset4", 0, idleRow(4'b0000, 32'h0, 2'd0));
    checkOutput("reset1", 1, idleRow(4'b0000, 32'h0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 4'b0000;
    data  = 32'h0;
    ordy  = 1'b0;

    // All four requesting: a,b,c,d,a,b,c,d, 4 beats each, one idle cycle between.
    vecs.push_back(idleRow(4'hF, D1, 2'd0));
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++)
        vecs.push_back(grantRow(4'hF, D1, 1'b1, 2'(b % 4), 1'b1, 8'(8'h11 * ((b % 4) + 1))));
      if (b < 7) vecs.push_back(idleRow(4'hF, D1, 2'(b % 4)));
    end
    // Only c requesting, 10 beats: bursts of 4,4,2, then c drops valid.
    vecs.push_back(idleRow(4'b0100, 32'h0, 2'd3));
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(grantRow(4'b0100, 32'(k) << 16, 1'b1, 2'd2, 1'b1, 8'(k)));
      if (k == 3 || k == 7) vecs.push_back(idleRow(4'b0100, 32'(k + 1) << 16, 2'd2));
    end
    vecs.push_back(mk(4'b0000, 32'h0, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 4'b0100, 8'h00));
    // a drops valid after 2 beats while d waits; d next, then a again.
    vecs.push_back(idleRow(4'b0001, D1, 2'd2));
    vecs.push_back(grantRow(4'b1001, D1, 1'b1, 2'd0, 1'b1, 8'h11));
    vecs.push_back(grantRow(4'b1001, D1, 1'b1, 2'd0, 1'b1, 8'h11));
    vecs.push_back(mk(4'b1000, D1, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0001, 8'h00));
    vecs.push_back(idleRow(4'b1001, D1, 2'd0));
    for (int k = 0; k < 4; k++) vecs.push_back(grantRow(4'b1001, D1, 1'b1, 2'd3, 1'b1, 8'h44));
    vecs.push_back(idleRow(4'b0001, D1, 2'd3));
    for (int k = 0; k < 4; k++) vecs.push_back(grantRow(4'b0001, D1, 1'b1, 2'd0, 1'b1, 8'h11));
    vecs.push_back(idleRow(4'b0000, D1, 2'd0));
    vecs.push_back(idleRow(4'b0000, D1, 2'd0));

    $display("[TB] starting table of %0d vectors", vecs.size());
    doReset();
    for (int i = 0; i < vecs.size(); i++)
      runVec($sformatf("vec%0d", i), 0, vecs[i]);

    // b stalled by out_ready=0 for 20 cycles; no beat lost or duplicated afterwards.
    doReset();
    runVec("stall.idle", 0, mk(4'b0010, 32'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'h00));
    for (int k = 0; k < 20; k++)
      runVec($sformatf("stall.hold%0d", k), 0, grantRow(4'b0010, 32'h0, 1'b0, 2'd1, 1'b1, 8'h00));
    for (int k = 0; k < 6; k++) begin
      runVec($sformatf("stall.beat%0d", k), 0, grantRow(4'b0010, 32'(k) << 8, 1'b1, 2'd1, 1'b1, 8'(k)));
      if (k == 3) runVec("stall.gap", 0, idleRow(4'b0010, 32'(4) << 8, 2'd1));
    end
    runVec("stall.drop", 0, mk(4'b0000, 32'h0, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0010, 8'h00));
    runVec("stall.end", 0, idleRow(4'b0000, 32'h0, 2'd1));

    // Asynchronous reset in the middle of a c burst, then priority restarts at a.
    doReset();
    runVec("rst.idle", 0, idleRow(4'b0100, D1, 2'd0));
    runVec("rst.c0", 0, grantRow(4'b0100, D1, 1'b1, 2'd2, 1'b1, 8'h33));
    runVec("rst.c1", 0, grantRow(4'b0100, D1, 1'b1, 2'd2, 1'b1, 8'h33));
    @(posedge clk);
    #1;
    valid = 4'b0101;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.midburst", 0, idleRow(4'b0101, D1, 2'd0));
    #1;
    rst_n = 1'b1;
    runVec("rst.a", 0, grantRow(4'b0101, D1, 1'b1, 2'd0, 1'b1, 8'h11));
    for (int k = 0; k < 3; k++)
      runVec($sformatf("rst.a%0d", k + 1), 0, grantRow(4'b0101, D1, 1'b1, 2'd0, 1'b1, 8'h11));
    runVec("rst.gap", 0, idleRow(4'b0101, D1, 2'd0));
    runVec("rst.c", 0, grantRow(4'b0101, D1, 1'b1, 2'd2, 1'b1, 8'h33));

    // BURST_LEN=1: a and c alternate single beats with one idle cycle between.
    doReset();
    runVec("b1.idle", 1, idleRow(4'b0101, D1, 2'd0));
    for (int k = 0; k < 4; k++) begin
      runVec($sformatf("b1.grant%0d", k), 1,
             grantRow(4'b0101, D1, 1'b1, (k % 2 == 0) ? 2'd0 : 2'd2, 1'b1, (k % 2 == 0) ? 8'h11 : 8'h33));
      runVec($sformatf("b1.gap%0d", k), 1, idleRow(4'b0101, D1, (k % 2 == 0) ? 2'd0 : 2'd2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
